mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master (instruction fetch / data) arbiter onto a single-ported memory with
// fixed read latency; one access outstanding, D-priority with an I starvation guard.
module mem_arbiter #(
    parameter int unsigned LAT        = 1,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_cen,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int unsigned CW = 3;
    localparam int unsigned SW = 4;

    typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [SW-1:0] streak, streak_nxt;
    logic          owner_d, owner_nxt;
    logic          lat_wen, lat_wen_nxt;

    logic          mem_cen_nxt, mem_wen_nxt, i_ack_nxt, d_ack_nxt, busy_nxt;
    logic [31:0]   mem_addr_nxt, mem_wdata_nxt, i_rdata_nxt, d_rdata_nxt;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            streak    <= '0;
            owner_d   <= 1'b0;
            lat_wen   <= 1'b0;
            mem_cen   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            streak    <= streak_nxt;
            owner_d   <= owner_nxt;
            lat_wen   <= lat_wen_nxt;
            mem_cen   <= mem_cen_nxt;
            mem_wen   <= mem_wen_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            i_ack     <= i_ack_nxt;
            d_ack     <= d_ack_nxt;
            i_rdata   <= i_rdata_nxt;
            d_rdata   <= d_rdata_nxt;
            busy      <= busy_nxt;
        end
    end

    // Outputs are computed one cycle ahead so they line up with the state they belong to
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        streak_nxt    = streak;
        owner_nxt     = owner_d;
        lat_wen_nxt   = lat_wen;
        mem_cen_nxt   = 1'b0;
        mem_wen_nxt   = 1'b0;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        i_ack_nxt     = 1'b0;
        d_ack_nxt     = 1'b0;
        i_rdata_nxt   = i_rdata;
        d_rdata_nxt   = d_rdata;

        unique case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    // The memory address/data registers double as the request latch
                    if (d_req && !(i_req && streak == SW'(MAX_STREAK))) begin
                        owner_nxt     = 1'b1;
                        lat_wen_nxt   = d_wen;
                        mem_addr_nxt  = d_addr;
                        mem_wdata_nxt = d_wdata;
                        if (i_req) streak_nxt = streak + SW'(1);
                    end else begin
                        owner_nxt    = 1'b0;
                        lat_wen_nxt  = 1'b0;
                        mem_addr_nxt = i_addr;
                        streak_nxt   = '0;
                    end
                    mem_cen_nxt = 1'b1;
                    mem_wen_nxt = lat_wen_nxt;
                    state_nxt   = CMD;
                end
            end
            CMD: begin
                cnt_nxt   = CW'(1);
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == CW'(LAT)) begin
                    if (!lat_wen) begin
                        if (owner_d) d_rdata_nxt = mem_rdata;
                        else         i_rdata_nxt = mem_rdata;
                    end
                    d_ack_nxt = owner_d;
                    i_ack_nxt = !owner_d;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of grant, timing and data rules.
module tb_mem_arbiter;

    localparam int unsigned LAT1 = 1;
    localparam int unsigned LAT3 = 3;
    localparam int unsigned MAXS = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        i_req, i_ack, d_req, d_wen, d_ack, mem_cen, mem_wen, busy;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        x_i_req, x_i_ack, x_d_req, x_d_wen, x_d_ack, x_mem_cen, x_mem_wen, x_busy;
    logic [31:0] x_i_addr, x_i_rdata, x_d_addr, x_d_wdata, x_d_rdata;
    logic [31:0] x_mem_addr, x_mem_wdata, x_mem_rdata;

    mem_arbiter #(.LAT(LAT1), .MAX_STREAK(MAXS)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.LAT(LAT3), .MAX_STREAK(MAXS)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .i_req(x_i_req), .i_addr(x_i_addr), .i_ack(x_i_ack), .i_rdata(x_i_rdata),
        .d_req(x_d_req), .d_wen(x_d_wen), .d_addr(x_d_addr), .d_wdata(x_d_wdata),
        .d_ack(x_d_ack), .d_rdata(x_d_rdata),
        .mem_cen(x_mem_cen), .mem_wen(x_mem_wen), .mem_addr(x_mem_addr),
        .mem_wdata(x_mem_wdata), .mem_rdata(x_mem_rdata), .busy(x_busy)
    );

    // Memory contents; unwritten words read back as an address-derived pattern
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : ((a ^ 32'h5EED_0000) + 32'd7);
    endfunction

    // Read data is valid exactly LAT cycles after the command, noise otherwise
    logic [31:0] pipe1 = '0;
    logic [31:0] xp1 = '0, xp2 = '0, xp3 = '0;
    always @(posedge clk) begin
        pipe1 <= (mem_cen && !mem_wen) ? mem_rd(mem_addr) : 32'($urandom);
        xp1   <= (x_mem_cen && !x_mem_wen) ? (x_mem_addr ^ 32'hC0DE_0000) : 32'($urandom);
        xp2   <= xp1;
        xp3   <= xp2;
    end
    assign mem_rdata   = pipe1;
    assign x_mem_rdata = xp3;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Transaction-level reference model
    int          cyc = 0;
    int          free_cyc = 0;
    int          t_g = -100;
    bit          t_i, t_wen;
    logic [31:0] t_addr, t_wdata, t_rdata;
    int          streak_m = 0;
    logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;

    task automatic model_reset();
        free_cyc = cyc;
        t_g      = -100;
        t_i      = 1'b0;
        t_wen    = 1'b0;
        streak_m = 0;
        m_addr   = '0;
        m_wdata  = '0;
        m_irdata = '0;
        m_drdata = '0;
    endtask

    task automatic model_arb();
        bit pick_i;
        if (rst_n && cyc >= free_cyc && (i_req || d_req)) begin
            pick_i   = !d_req || (i_req && streak_m == int'(MAXS));
            t_i      = pick_i;
            t_g      = cyc;
            free_cyc = cyc + int'(LAT1) + 3;
            if (pick_i) begin
                t_addr   = i_addr;
                t_wen    = 1'b0;
                t_wdata  = m_wdata;
                streak_m = 0;
            end else begin
                t_addr  = d_addr;
                t_wen   = d_wen;
                t_wdata = d_wdata;
                if (i_req && streak_m < int'(MAXS)) streak_m++;
            end
            t_rdata = mem_rd(t_addr);
        end
    endtask

    task automatic check_outputs();
        bit cen_e, ack_e, busy_e;
        cen_e  = (cyc == t_g + 1);
        ack_e  = (cyc == t_g + 2 + int'(LAT1));
        busy_e = (cyc > t_g) && (cyc <= t_g + 2 + int'(LAT1));
        if (cen_e) begin
            m_addr  = t_addr;
            m_wdata = t_wdata;
        end
        if (ack_e && !t_wen) begin
            if (t_i) m_irdata = t_rdata;
            else     m_drdata = t_rdata;
        end
        chk("mem_cen",   32'(mem_cen), 32'(cen_e));
        chk("mem_wen",   32'(mem_wen), 32'(cen_e && t_wen));
        chk("mem_addr",  mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("i_ack",     32'(i_ack), 32'(ack_e && t_i));
        chk("d_ack",     32'(d_ack), 32'(ack_e && !t_i));
        chk("i_rdata",   i_rdata, m_irdata);
        chk("d_rdata",   d_rdata, m_drdata);
        chk("busy",      32'(busy), 32'(busy_e));
        if (mem_cen && mem_wen) mem[mem_addr] = mem_wdata;
    endtask

    task automatic cycle();
        model_arb();
        @(posedge clk);
        #1;
        cyc++;
        if (rst_n) check_outputs();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_iack"},  32'(i_ack), 32'd0);
        chk({tag, "_dack"},  32'(d_ack), 32'd0);
        chk({tag, "_cen"},   32'(mem_cen), 32'd0);
        chk({tag, "_wen"},   32'(mem_wen), 32'd0);
        chk({tag, "_addr"},  mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_irdat"}, i_rdata, 32'd0);
        chk({tag, "_drdat"}, d_rdata, 32'd0);
    endtask

    function automatic logic [31:0] rnd_addr();
        return 32'h0000_2000 + 32'($urandom_range(0, 15) << 2);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          t0, nack;
        bit          ord[$];
        bit          exp_ord[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        logic [31:0] obs4;
        bit          i_done, i_fl, d_done, d_fl;

        rst_n = 1'b0;
        i_req = 0; i_addr = '0; d_req = 0; d_wen = 0; d_addr = '0; d_wdata = '0;
        x_i_req = 0; x_i_addr = '0; x_d_req = 0; x_d_wen = 0; x_d_addr = '0; x_d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst");
        chk("rst_x_busy", 32'(x_busy), 32'd0);
        chk("rst_x_cen",  32'(x_mem_cen), 32'd0);
        chk("rst_x_ack",  32'(x_i_ack | x_d_ack), 32'd0);
        chk("rst_x_data", x_i_rdata | x_d_rdata | x_mem_wdata, 32'd0);
        rst_n = 1'b1;
        model_reset();

        // Fetch with LAT=1: command at T+1, ack and data at T+3
        mem[32'h0001_0000] = 32'h0000_0013;
        i_req = 1; i_addr = 32'h0001_0000;
        t0 = cyc;
        cycle();
        chk("f_cen",  32'(mem_cen), 32'd1);
        chk("f_addr", mem_addr, 32'h0001_0000);
        cycle();
        cycle();
        chk("f_lat",   32'(cyc - t0), 32'd3);
        chk("f_ack",   32'(i_ack), 32'd1);
        chk("f_rdata", i_rdata, 32'h0000_0013);
        i_req = 0;
        repeat (2) cycle();

        // Data write, then read it back
        d_req = 1; d_wen = 1; d_addr = 32'h0001_0100; d_wdata = 32'hDEAD_BEEF;
        cycle();
        chk("w_cen",   32'(mem_cen), 32'd1);
        chk("w_wen",   32'(mem_wen), 32'd1);
        chk("w_addr",  mem_addr, 32'h0001_0100);
        chk("w_wdata", mem_wdata, 32'hDEAD_BEEF);
        cycle();
        cycle();
        chk("w_ack",   32'(d_ack), 32'd1);
        chk("w_rdata", d_rdata, 32'd0);
        d_req = 0;
        cycle();
        d_req = 1; d_wen = 0;
        repeat (3) cycle();
        chk("rb_ack",   32'(d_ack), 32'd1);
        chk("rb_rdata", d_rdata, 32'hDEAD_BEEF);
        d_req = 0;
        cycle();

        // Address changed while the access is in flight
        d_req = 1; d_wen = 0; d_addr = 32'h0000_0400;
        cycle();
        chk("chg_addr0", mem_addr, 32'h0000_0400);
        cycle();
        d_addr = 32'h0000_0800;
        cycle();
        chk("chg_ack", 32'(d_ack), 32'd1);
        cycle();
        cycle();
        chk("chg_cen",   32'(mem_cen), 32'd1);
        chk("chg_addr1", mem_addr, 32'h0000_0800);
        d_req = 0;
        repeat (4) cycle();

        // Both masters held: D wins MAX_STREAK times, then I
        i_req = 1; i_addr = 32'h0000_1000; d_req = 1; d_wen = 0; d_addr = 32'h0000_1100;
        nack = 0;
        for (int k = 0; k < 200 && nack < 10; k++) begin
            cycle();
            if (i_ack) begin ord.push_back(1'b1); nack++; end
            if (d_ack) begin ord.push_back(1'b0); nack++; end
        end
        chk("ord_count", 32'(ord.size()), 32'd10);
        for (int k = 0; k < 10 && k < ord.size(); k++)
            chk($sformatf("ord_%0d", k), 32'(ord[k]), 32'(exp_ord[k]));
        i_req = 0; d_req = 0;
        repeat (5) cycle();

        // Reset during WAIT abandons the access; held request then completes
        i_req = 1; i_addr = 32'h0000_3000;
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_cen",  32'(mem_cen), 32'd0);
        @(posedge clk); #1; cyc++;
        chk_zero("ar");
        @(posedge clk); #1; cyc++;
        rst_n = 1'b1;
        model_reset();
        t0 = cyc;
        repeat (3) cycle();
        chk("ar_relat", 32'(cyc - t0), 32'd3);
        chk("ar_ack",   32'(i_ack), 32'd1);
        chk("ar_rdata", i_rdata, mem_rd(32'h0000_3000));
        i_req = 0;
        repeat (2) cycle();

        // LAT=3 instance: ack five cycles after the request
        x_d_req = 1; x_d_wen = 0; x_d_addr = 32'h0000_0300;
        obs4 = '0;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            if (k == 1) chk("l3_cen", 32'(x_mem_cen), 32'd1);
            if (k == 4) begin
                obs4 = x_mem_rdata;
                chk("l3_noack", 32'(x_d_ack), 32'd0);
            end
        end
        chk("l3_ack",    32'(x_d_ack), 32'd1);
        chk("l3_rdata",  x_d_rdata, obs4);
        chk("l3_value",  x_d_rdata, 32'h0000_0300 ^ 32'hC0DE_0000);
        x_d_req = 0;
        cycle();

        // Randomized traffic against the model
        for (int k = 0; k < 1500; k++) begin
            i_done = t_i && (cyc == t_g + 2 + int'(LAT1));
            d_done = !t_i && (cyc == t_g + 2 + int'(LAT1));
            i_fl   = t_i && (t_g < cyc) && (cyc < t_g + 2 + int'(LAT1));
            d_fl   = !t_i && (t_g < cyc) && (cyc < t_g + 2 + int'(LAT1));
            if (i_done) begin
                i_req = 1'($urandom_range(0, 1)); i_addr = rnd_addr();
            end else if (i_fl) begin
                if ($urandom_range(0, 3) == 0) i_addr = rnd_addr();
            end else if (!i_req) begin
                if ($urandom_range(0, 3) == 0) begin i_req = 1; i_addr = rnd_addr(); end
            end else if ($urandom_range(0, 15) == 0) begin
                i_req = 0;
            end
            if (d_done) begin
                d_req = 1'($urandom_range(0, 1)); d_addr = rnd_addr();
                d_wen = 1'($urandom_range(0, 1)); d_wdata = 32'($urandom);
            end else if (d_fl) begin
                if ($urandom_range(0, 3) == 0) begin d_addr = rnd_addr(); d_wdata = 32'($urandom); end
            end else if (!d_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    d_req = 1; d_addr = rnd_addr();
                    d_wen = 1'($urandom_range(0, 1)); d_wdata = 32'($urandom);
                end
            end else if ($urandom_range(0, 15) == 0) begin
                d_req = 0;
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
